// File: rtl/pulse_decoder_pkg.sv
// Shared types and constants for the LED serial pulse decoder.
// Default tick thresholds assume the tick rate produced by count_enable's DIVISOR.
package pulse_decoder_pkg;

  localparam int unsigned PIXEL_W   = 24;
  localparam int unsigned BIT_IDX_W = 5;
  localparam int unsigned STAT_W    = 16;

  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_MIN_HIGH    = 4;
  localparam int unsigned DEF_ONE_THRESH  = 12;
  localparam int unsigned DEF_MAX_HIGH    = 24;
  localparam int unsigned DEF_LATCH_TICKS = 1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_ERROR = 2'd3
  } dec_state_t;

  // True when idx addresses the last bit of a pixel word.
  function automatic logic is_last_bit(input logic [BIT_IDX_W-1:0] idx);
    return idx == BIT_IDX_W'(PIXEL_W - 1);
  endfunction

endpackage

// File: rtl/pulse_decoder_if.sv
// Edge/tick inputs and decoded outputs of pulse_decoder.
// PULSE_DECODER_STATS_EN adds the error and pixel statistics counters.
interface pulse_decoder_if;
  import pulse_decoder_pkg::*;

  logic               i_count_enable;
  logic               i_rising;
  logic               i_falling;
  logic               o_bit_valid;
  logic               o_bit;
  logic               o_pixel_valid;
  logic [PIXEL_W-1:0] o_pixel;
  logic               o_latch;
  logic               o_error;
`ifdef PULSE_DECODER_STATS_EN
  logic [STAT_W-1:0]  o_err_count;
  logic [STAT_W-1:0]  o_pixel_count;
`endif

  modport master (
    output i_count_enable, i_rising, i_falling,
    input  o_bit_valid, o_bit, o_pixel_valid, o_pixel, o_latch, o_error
`ifdef PULSE_DECODER_STATS_EN
    , input o_err_count, o_pixel_count
`endif
  );

  modport slave (
    input  i_count_enable, i_rising, i_falling,
    output o_bit_valid, o_bit, o_pixel_valid, o_pixel, o_latch, o_error
`ifdef PULSE_DECODER_STATS_EN
    , output o_err_count, o_pixel_count
`endif
  );

endinterface

// File: rtl/sat_tick_counter.sv
// Tick counter that saturates at all-ones; clear has priority over enable.
module sat_tick_counter #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clear,
  input  logic         i_enable,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] TOP = '1;

  always_ff @(posedge i_clk) begin : p_count
    if (i_reset || i_clear) begin
      o_count <= '0;
    end else if (i_enable && (o_count != TOP)) begin
      o_count <= o_count + W'(1);
    end
  end

endmodule

// File: rtl/pulse_decoder.sv
// Measures LED data-line pulse widths, decodes bits, assembles 24-bit pixels,
// and flags latch gaps and malformed pulses. PULSE_DECODER_STATS_EN adds counters.
module pulse_decoder
  import pulse_decoder_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned MIN_HIGH    = DEF_MIN_HIGH,
  parameter int unsigned ONE_THRESH  = DEF_ONE_THRESH,
  parameter int unsigned MAX_HIGH    = DEF_MAX_HIGH,
  parameter int unsigned LATCH_TICKS = DEF_LATCH_TICKS
) (
  input  logic              i_clk,
  input  logic              i_reset,
  pulse_decoder_if.slave    dec
);

  localparam longint unsigned CNT_TOP = (64'd1 << CNT_W) - 64'd1;

  generate
    if (!((MIN_HIGH <= ONE_THRESH) && (ONE_THRESH <= MAX_HIGH) &&
          (64'(MAX_HIGH) < CNT_TOP) && (64'(LATCH_TICKS) <= CNT_TOP) &&
          (LATCH_TICKS >= 1))) begin : g_bad_params
      $error("pulse_decoder: illegal threshold/width parameter combination");
    end
  endgenerate

  localparam logic [CNT_W-1:0] MIN_C        = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(ONE_THRESH);
  localparam logic [CNT_W-1:0] MAX_C        = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] LATCH_LAST_C = CNT_W'(LATCH_TICKS - 1);

  dec_state_t         state_q;
  logic [CNT_W-1:0]   high_cnt;
  logic [CNT_W-1:0]   low_cnt;
  logic [BIT_IDX_W-1:0] bit_idx_q;
  logic [PIXEL_W-1:0] shift_q;
  logic [PIXEL_W-1:0] pixel_q;
  logic               bit_valid_q;
  logic               bit_q;
  logic               pixel_valid_q;
  logic               latch_q;
  logic               error_q;

  logic               both_edges_c;
  logic               any_edge_c;
  logic               ev_start;
  logic               ev_bit;
  logic               ev_err;
  logic               ev_latch;
  logic               ev_quiet;
  logic               err_edge_clr;
  logic               hi_en;
  logic               lo_en;
  logic               hi_clr;
  logic               lo_clr;
  logic               bit_val_c;
  logic               pixel_done_c;
  logic [PIXEL_W-1:0] new_word_c;

  assign both_edges_c = dec.i_rising & dec.i_falling;
  assign any_edge_c   = dec.i_rising | dec.i_falling;
  assign bit_val_c    = (high_cnt >= ONE_C);
  assign pixel_done_c = ev_bit & is_last_bit(bit_idx_q);
  assign new_word_c   = {shift_q[PIXEL_W-2:0], bit_val_c};
  assign hi_clr       = ev_start;
  assign lo_clr       = ev_bit | ev_err | ev_latch | ev_quiet | err_edge_clr;

  // Event decode: edges take priority over a coincident tick.
  always_comb begin : p_decode
    ev_start     = 1'b0;
    ev_bit       = 1'b0;
    ev_err       = 1'b0;
    ev_latch     = 1'b0;
    ev_quiet     = 1'b0;
    err_edge_clr = 1'b0;
    hi_en        = 1'b0;
    lo_en        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (both_edges_c)      ev_err   = 1'b1;
        else if (dec.i_rising) ev_start = 1'b1;
      end
      ST_HIGH: begin
        if (dec.i_rising) begin
          ev_err = 1'b1;
        end else if (dec.i_falling) begin
          if (high_cnt < MIN_C) ev_err = 1'b1;
          else                  ev_bit = 1'b1;
        end else if (dec.i_count_enable) begin
          if (high_cnt == MAX_C) ev_err = 1'b1;
          else                   hi_en  = 1'b1;
        end
      end
      ST_LOW: begin
        if (both_edges_c) begin
          ev_err = 1'b1;
        end else if (dec.i_rising) begin
          ev_start = 1'b1;
        end else if (dec.i_count_enable) begin
          if (low_cnt == LATCH_LAST_C) ev_latch = 1'b1;
          else                         lo_en    = 1'b1;
        end
      end
      ST_ERROR: begin
        if (any_edge_c) begin
          err_edge_clr = 1'b1;
        end else if (dec.i_count_enable) begin
          if (low_cnt == LATCH_LAST_C) ev_quiet = 1'b1;
          else                         lo_en    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  sat_tick_counter #(.W(CNT_W)) u_high_cnt (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (hi_clr),
    .i_enable (hi_en),
    .o_count  (high_cnt)
  );

  sat_tick_counter #(.W(CNT_W)) u_low_cnt (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (lo_clr),
    .i_enable (lo_en),
    .o_count  (low_cnt)
  );

  // State, pixel assembly and registered strobes.
  always_ff @(posedge i_clk) begin : p_fsm
    if (i_reset) begin
      state_q       <= ST_IDLE;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      pixel_q       <= '0;
      bit_valid_q   <= 1'b0;
      bit_q         <= 1'b0;
      pixel_valid_q <= 1'b0;
      latch_q       <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      bit_valid_q   <= ev_bit;
      pixel_valid_q <= pixel_done_c;
      latch_q       <= ev_latch;
      error_q       <= ev_err;

      if (ev_bit) begin
        bit_q     <= bit_val_c;
        shift_q   <= new_word_c;
        bit_idx_q <= pixel_done_c ? '0 : bit_idx_q + BIT_IDX_W'(1);
        if (pixel_done_c) pixel_q <= new_word_c;
      end
      if (ev_err || ev_latch) begin
        bit_idx_q <= '0;
        shift_q   <= '0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (ev_err)        state_q <= ST_ERROR;
          else if (ev_start) state_q <= ST_HIGH;
        end
        ST_HIGH: begin
          if (ev_err)      state_q <= ST_ERROR;
          else if (ev_bit) state_q <= ST_LOW;
        end
        ST_LOW: begin
          if (ev_err)        state_q <= ST_ERROR;
          else if (ev_start) state_q <= ST_HIGH;
          else if (ev_latch) state_q <= ST_IDLE;
        end
        ST_ERROR: begin
          if (ev_quiet) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dec.o_bit_valid   = bit_valid_q;
  assign dec.o_bit         = bit_q;
  assign dec.o_pixel_valid = pixel_valid_q;
  assign dec.o_pixel       = pixel_q;
  assign dec.o_latch       = latch_q;
  assign dec.o_error       = error_q;

`ifdef PULSE_DECODER_STATS_EN
  localparam logic [STAT_W-1:0] STAT_TOP = '1;

  logic [STAT_W-1:0] err_count_q;
  logic [STAT_W-1:0] pixel_count_q;

  // Counters move in the same cycle as the strobe they count.
  always_ff @(posedge i_clk) begin : p_stats
    if (i_reset) begin
      err_count_q   <= '0;
      pixel_count_q <= '0;
    end else begin
      if (ev_err && (err_count_q != STAT_TOP)) err_count_q <= err_count_q + STAT_W'(1);
      if (ev_latch) begin
        pixel_count_q <= '0;
      end else if (pixel_done_c && (pixel_count_q != STAT_TOP)) begin
        pixel_count_q <= pixel_count_q + STAT_W'(1);
      end
    end
  end

  assign dec.o_err_count   = err_count_q;
  assign dec.o_pixel_count = pixel_count_q;
`endif

endmodule

// File: tb/tb_pulse_decoder.sv
// Self-checking bench for pulse_decoder: pulse-level reference model plus directed cases.
module tb_pulse_decoder;
  import pulse_decoder_pkg::*;

  localparam int unsigned MIN_H = 4;
  localparam int unsigned ONE_T = 12;
  localparam int unsigned MAX_H = 24;
  localparam int unsigned LATCH = 1000;

  localparam int PH_IDLE = 0;
  localparam int PH_HIGH = 1;
  localparam int PH_LOW  = 2;
  localparam int PH_ERR  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pulse_decoder_if dec_if ();

  pulse_decoder #(
    .CNT_W(16), .MIN_HIGH(MIN_H), .ONE_THRESH(ONE_T),
    .MAX_HIGH(MAX_H), .LATCH_TICKS(LATCH)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .dec     (dec_if)
  );

  initial forever #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: phase of the line, tick tallies and received bits.
  int          m_phase;
  int          m_hi;
  int          m_lo;
  bit          bits_q[$];
  logic        e_bv, e_b, e_pv, e_latch, e_err;
  logic [23:0] e_pix;
  int          e_errc, e_pixc;

  int obs_bv, obs_pv, obs_latch, obs_err;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void m_error();
    e_err   = 1'b1;
    bits_q.delete();
    m_lo    = 0;
    m_phase = PH_ERR;
    if (e_errc < 65535) e_errc++;
  endfunction

  function automatic void m_emit(input bit b);
    e_bv = 1'b1;
    e_b  = b;
    bits_q.push_back(b);
    m_lo    = 0;
    m_phase = PH_LOW;
    if (bits_q.size() == int'(PIXEL_W)) begin
      for (int i = 0; i < int'(PIXEL_W); i++) e_pix[23-i] = bits_q[i];
      e_pv = 1'b1;
      bits_q.delete();
      if (e_pixc < 65535) e_pixc++;
    end
  endfunction

  function automatic void m_step(input bit r, input bit f, input bit t, input bit rs);
    e_bv = 1'b0; e_pv = 1'b0; e_latch = 1'b0; e_err = 1'b0;
    if (rs) begin
      m_phase = PH_IDLE; m_hi = 0; m_lo = 0; bits_q.delete();
      e_b = 1'b0; e_pix = '0; e_errc = 0; e_pixc = 0;
      return;
    end
    case (m_phase)
      PH_IDLE: begin
        if (r && f)  m_error();
        else if (r) begin m_phase = PH_HIGH; m_hi = 0; end
      end
      PH_HIGH: begin
        if (r) m_error();
        else if (f) begin
          if (m_hi < int'(MIN_H)) m_error();
          else m_emit(m_hi >= int'(ONE_T));
        end else if (t) begin
          m_hi++;
          if (m_hi > int'(MAX_H)) m_error();
        end
      end
      PH_LOW: begin
        if (r && f) m_error();
        else if (r) begin m_phase = PH_HIGH; m_hi = 0; end
        else if (t) begin
          m_lo++;
          if (m_lo == int'(LATCH)) begin
            e_latch = 1'b1; bits_q.delete(); m_phase = PH_IDLE; e_pixc = 0;
          end
        end
      end
      default: begin
        if (r || f) m_lo = 0;
        else if (t) begin
          m_lo++;
          if (m_lo == int'(LATCH)) m_phase = PH_IDLE;
        end
      end
    endcase
  endfunction

  // One clock: drive, advance the model, then compare every output.
  task automatic step(input bit r, input bit f, input bit t, input bit rs = 1'b0);
    dec_if.i_rising       = r;
    dec_if.i_falling      = f;
    dec_if.i_count_enable = t;
    rst                   = rs;
    m_step(r, f, t, rs);
    @(posedge clk);
    #1;
    chk("bit_valid",   32'(dec_if.o_bit_valid),   32'(e_bv));
    chk("bit",         32'(dec_if.o_bit),         32'(e_b));
    chk("pixel_valid", 32'(dec_if.o_pixel_valid), 32'(e_pv));
    chk("pixel",       32'(dec_if.o_pixel),       32'(e_pix));
    chk("latch",       32'(dec_if.o_latch),       32'(e_latch));
    chk("error",       32'(dec_if.o_error),       32'(e_err));
`ifdef PULSE_DECODER_STATS_EN
    chk("err_count",   32'(dec_if.o_err_count),   32'(e_errc));
    chk("pixel_count", 32'(dec_if.o_pixel_count), 32'(e_pixc));
`endif
    obs_bv    += int'(dec_if.o_bit_valid);
    obs_pv    += int'(dec_if.o_pixel_valid);
    obs_latch += int'(dec_if.o_latch);
    obs_err   += int'(dec_if.o_error);
  endtask

  task automatic pulse(input int n, input bit fall = 1'b1);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    if (fall) step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic lows(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  // Sends a word MSB first; ends right after the last falling edge.
  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) begin
      pulse(w[i] ? 16 : 8);
      if (i != 0) lows(3);
    end
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      pulse((i % 2 == 0) ? 16 : 8);
      lows(2);
    end
  endtask

  task automatic word_test(input string name, input logic [23:0] w);
    int pv0;
    pv0 = obs_pv;
    send_word(w);
    chk({name, "_pv"},    32'(dec_if.o_pixel_valid), 32'd1);
    chk({name, "_bv"},    32'(dec_if.o_bit_valid),   32'd1);
    chk({name, "_pix"},   32'(dec_if.o_pixel),       32'(w));
    chk({name, "_npv"},   32'(obs_pv - pv0),         32'd1);
    lows(3);
  endtask

  int l0, p0, b0, e0;

  initial begin
    dec_if.i_rising = 1'b0; dec_if.i_falling = 1'b0; dec_if.i_count_enable = 1'b0;
    obs_bv = 0; obs_pv = 0; obs_latch = 0; obs_err = 0;

    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("rst_bit_valid", 32'(dec_if.o_bit_valid),   32'd0);
    chk("rst_pixel",     32'(dec_if.o_pixel),       32'd0);
    chk("rst_latch",     32'(dec_if.o_latch),       32'd0);
    chk("rst_error",     32'(dec_if.o_error),       32'd0);
    step(1'b0, 1'b1, 1'b1);

    // Short and long valid pulses
    pulse(8);
    chk("bit8_valid", 32'(dec_if.o_bit_valid), 32'd1);
    chk("bit8_value", 32'(dec_if.o_bit),       32'd0);
    chk("model_bit8", 32'(e_b),                32'd0);
    lows(3);
    pulse(16);
    chk("bit16_valid", 32'(dec_if.o_bit_valid), 32'd1);
    chk("bit16_value", 32'(dec_if.o_bit),       32'd1);
    l0 = obs_latch;
    lows(int'(LATCH));
    chk("latch_after_two", 32'(obs_latch - l0), 32'd1);

    word_test("pix_a5c30f", 24'hA5C30F);
    chk("model_pix", 32'(e_pix), 32'hA5C30F);

    // Partial pixel dropped by latch gap
    send_bits(10);
    l0 = obs_latch; p0 = obs_pv;
    lows(int'(LATCH));
    chk("latch_once",       32'(obs_latch - l0), 32'd1);
    chk("latch_no_pixel",   32'(obs_pv - p0),    32'd0);
    word_test("pix_after_latch", 24'h123456);
    lows(int'(LATCH));

    // Glitch, stuck-high, and quiet recovery
    pulse(2);
    chk("glitch_err", 32'(dec_if.o_error), 32'd1);
    l0 = obs_latch;
    lows(int'(LATCH));
    chk("glitch_no_latch", 32'(obs_latch - l0), 32'd0);
    pulse(25, 1'b0);
    chk("stuck_err", 32'(dec_if.o_error), 32'd1);
    b0 = obs_bv; e0 = obs_err; l0 = obs_latch;
    pulse(8); lows(5); pulse(16); lows(5);
    lows(int'(LATCH));
    chk("err_ignored_bits", 32'(obs_bv - b0),     32'd0);
    chk("err_no_new_err",   32'(obs_err - e0),    32'd0);
    chk("err_no_latch",     32'(obs_latch - l0),  32'd0);
    word_test("pix_after_err", 24'h0F0F0F);
    lows(int'(LATCH));

    // Simultaneous edges while high
    step(1'b1, 1'b0, 1'b0);
    lows(5);
    step(1'b1, 1'b1, 1'b0);
    chk("both_edges_err", 32'(dec_if.o_error), 32'd1);
    lows(int'(LATCH));

    // Reset mid-pixel
    send_bits(12);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("midrst_bv",    32'(dec_if.o_bit_valid),   32'd0);
    chk("midrst_pv",    32'(dec_if.o_pixel_valid), 32'd0);
    chk("midrst_pixel", 32'(dec_if.o_pixel),       32'd0);
    chk("midrst_error", 32'(dec_if.o_error),       32'd0);
    word_test("pix_after_rst", 24'h5A3C99);
    lows(int'(LATCH));

`ifdef PULSE_DECODER_STATS_EN
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      pulse(1);
      lows(int'(LATCH));
    end
    word_test("stat_pix1", 24'hABCDEF);
    word_test("stat_pix2", 24'h000001);
    chk("stat_err3", 32'(dec_if.o_err_count),   32'd3);
    chk("stat_pix2", 32'(dec_if.o_pixel_count), 32'd2);
    lows(int'(LATCH));
    chk("stat_pix_clr", 32'(dec_if.o_pixel_count), 32'd0);
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 80) begin
        int n;
        n = int'($urandom_range(0, 28));
        step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < n; i++) begin
          if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b0);
          step(1'b0, 1'b0, 1'b1);
        end
        step(1'b0, ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)));
        lows(int'($urandom_range(1, 6)));
      end else if (sel < 90) begin
        for (int i = 0; i < 20; i++)
          step(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      end else if (sel < 97) begin
        lows(int'($urandom_range(LATCH - 3, LATCH + 3)));
      end else begin
        step(1'b0, 1'b0, 1'b0, 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
